// File: rtl/vga_pixel_reader_if.sv
// Bundle between the merge stage / VGA timing (master) and the pixel reader (slave).
// Carries both 128-bit RGB line-buffer triplets, their full flags and the pixel output.
interface vga_pixel_reader_if;
    logic [127:0] R_inA, G_inA, B_inA;
    logic [127:0] R_inB, G_inB, B_inB;
    logic         full_A, full_B;
    logic         pixel_tick;
    logic         active_video;
    logic         readVgaSelector;
    logic [7:0]   R_out, G_out, B_out;
    logic         pixel_valid;
    logic         underrun;
    logic [15:0]  underrun_cnt;

    modport master (
        output R_inA, G_inA, B_inA, R_inB, G_inB, B_inB,
        output full_A, full_B, pixel_tick, active_video,
        input  readVgaSelector, R_out, G_out, B_out, pixel_valid, underrun, underrun_cnt
    );

    modport slave (
        input  R_inA, G_inA, B_inA, R_inB, G_inB, B_inB,
        input  full_A, full_B, pixel_tick, active_video,
        output readVgaSelector, R_out, G_out, B_out, pixel_valid, underrun, underrun_cnt
    );
endinterface

// File: rtl/vga_pixel_reader.sv
// Ping-pong line-buffer reader: snapshots a full A/B triplet and serializes 16 pixels per load.
// Optional underrun pixel counter enabled by defining VGA_READER_UNDERRUN_CNT_EN.
module vga_pixel_reader #(
    parameter logic [7:0] FALLBACK_R = 8'h00,
    parameter logic [7:0] FALLBACK_G = 8'h00,
    parameter logic [7:0] FALLBACK_B = 8'h00
) (
    input logic               clk,
    input logic               reset,
    vga_pixel_reader_if.slave bus
);

    typedef enum logic [1:0] {StWaitFill, StStream, StUnderrun} state_e;

    state_e       state_q, state_d;
    logic         sel_q, sel_d;
    logic [3:0]   idx_q, idx_d;
    logic [127:0] r_snap_q, r_snap_d;
    logic [127:0] g_snap_q, g_snap_d;
    logic [127:0] b_snap_q, b_snap_d;
    logic [7:0]   r_out_q, r_out_d;
    logic [7:0]   g_out_q, g_out_d;
    logic [7:0]   b_out_q, b_out_d;
    logic         valid_q, valid_d;

    logic fill_full;
    logic emit;
    logic last_pix;
    logic emit_snap;
    logic emit_fb;
    logic load;

    // Fill buffer is the one the reader does not own.
    assign fill_full = sel_q ? bus.full_A : bus.full_B;
    assign emit      = bus.pixel_tick && bus.active_video;
    assign last_pix  = (idx_q == 4'd15);
    assign emit_snap = (state_q == StStream) && emit;
    assign emit_fb   = (state_q == StUnderrun) && emit;
    assign load      = fill_full && ((state_q == StWaitFill) || (state_q == StUnderrun) ||
                                     (emit_snap && last_pix));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StWaitFill;
            sel_q    <= 1'b1;
            idx_q    <= 4'd0;
            r_snap_q <= '0;
            g_snap_q <= '0;
            b_snap_q <= '0;
            r_out_q  <= 8'h00;
            g_out_q  <= 8'h00;
            b_out_q  <= 8'h00;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            idx_q    <= idx_d;
            r_snap_q <= r_snap_d;
            g_snap_q <= g_snap_d;
            b_snap_q <= b_snap_d;
            r_out_q  <= r_out_d;
            g_out_q  <= g_out_d;
            b_out_q  <= b_out_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitFill: if (fill_full) state_d = StStream;
            StStream:   if (emit_snap && last_pix && !fill_full) state_d = StUnderrun;
            StUnderrun: if (fill_full) state_d = StStream;
            default:    state_d = StWaitFill;
        endcase
    end

    always_comb begin
        sel_d    = sel_q;
        idx_d    = idx_q;
        r_snap_d = r_snap_q;
        g_snap_d = g_snap_q;
        b_snap_d = b_snap_q;
        r_out_d  = r_out_q;
        g_out_d  = g_out_q;
        b_out_d  = b_out_q;
        valid_d  = 1'b0;

        // Pixel idx always sits in the low byte; the snapshot shifts down after each emission.
        if (emit_snap) begin
            r_out_d  = r_snap_q[7:0];
            g_out_d  = g_snap_q[7:0];
            b_out_d  = b_snap_q[7:0];
            valid_d  = 1'b1;
            r_snap_d = r_snap_q >> 8;
            g_snap_d = g_snap_q >> 8;
            b_snap_d = b_snap_q >> 8;
            idx_d    = idx_q + 4'd1;
        end

        if (emit_fb) begin
            r_out_d = FALLBACK_R;
            g_out_d = FALLBACK_G;
            b_out_d = FALLBACK_B;
            valid_d = 1'b1;
        end

        if (load) begin
            r_snap_d = sel_q ? bus.R_inA : bus.R_inB;
            g_snap_d = sel_q ? bus.G_inA : bus.G_inB;
            b_snap_d = sel_q ? bus.B_inA : bus.B_inB;
            sel_d    = ~sel_q;
            idx_d    = 4'd0;
        end
    end

    always_comb begin
        bus.readVgaSelector = sel_q;
        bus.R_out           = r_out_q;
        bus.G_out           = g_out_q;
        bus.B_out           = b_out_q;
        bus.pixel_valid     = valid_q;
        bus.underrun        = (state_q == StUnderrun);
    end

`ifdef VGA_READER_UNDERRUN_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (emit_fb && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= 16'h0000;
        else        cnt_q <= cnt_d;
    end

    assign bus.underrun_cnt = cnt_q;
`else
    assign bus.underrun_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_pixel_reader.sv
// Directed self-checking bench for vga_pixel_reader: load, seamless A->B, underrun, reset.
module tb_vga_pixel_reader;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

`ifdef VGA_READER_UNDERRUN_CNT_EN
    localparam int unsigned ExpCnt3 = 3;
    localparam int unsigned ExpCnt4 = 4;
`else
    localparam int unsigned ExpCnt3 = 0;
    localparam int unsigned ExpCnt4 = 0;
`endif

    vga_pixel_reader_if bus ();

    vga_pixel_reader #(
        .FALLBACK_R (8'hFF),
        .FALLBACK_G (8'h00),
        .FALLBACK_B (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] ramp(input int base);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < 16; k++) w[8*k +: 8] = 8'(base + k);
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pix(input string tag, input int r, input int g, input int b);
        check({tag, ".R"}, 32'(bus.R_out), 32'(r));
        check({tag, ".G"}, 32'(bus.G_out), 32'(g));
        check({tag, ".B"}, 32'(bus.B_out), 32'(b));
        check({tag, ".valid"}, 32'(bus.pixel_valid), 32'd1);
    endtask

    task automatic tick(input logic av);
        bus.pixel_tick   = 1'b1;
        bus.active_video = av;
        @(posedge clk);
        #1;
        bus.pixel_tick   = 1'b0;
        bus.active_video = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        bus.R_inA = '0; bus.G_inA = '0; bus.B_inA = '0;
        bus.R_inB = '0; bus.G_inB = '0; bus.B_inB = '0;
        bus.full_A = 1'b0;
        bus.full_B = 1'b0;
        bus.pixel_tick = 1'b0;
        bus.active_video = 1'b0;
        idle();
        idle();

        check("rst.sel", 32'(bus.readVgaSelector), 32'd1);
        check("rst.R", 32'(bus.R_out), 32'd0);
        check("rst.G", 32'(bus.G_out), 32'd0);
        check("rst.B", 32'(bus.B_out), 32'd0);
        check("rst.valid", 32'(bus.pixel_valid), 32'd0);
        check("rst.underrun", 32'(bus.underrun), 32'd0);
        check("rst.cnt", 32'(bus.underrun_cnt), 32'd0);

        // Load A.
        reset = 1'b1;
        bus.R_inA = ramp(8'h00); bus.G_inA = ramp(8'h10); bus.B_inA = ramp(8'h20);
        bus.R_inB = ramp(8'h80); bus.G_inB = ramp(8'h90); bus.B_inB = ramp(8'hA0);
        bus.full_A = 1'b1;
        idle();
        check("loadA.sel", 32'(bus.readVgaSelector), 32'd0);
        check("loadA.valid", 32'(bus.pixel_valid), 32'd0);
        bus.full_A = 1'b0;
        // Snapshot must not follow later input changes.
        bus.R_inA = {16{8'hEE}}; bus.G_inA = {16{8'hEE}}; bus.B_inA = {16{8'hEE}};

        for (int k = 0; k < 16; k++) begin
            if (k == 10) bus.full_B = 1'b1;
            tick(1'b1);
            check_pix($sformatf("A[%0d]", k), k, 16 + k, 32 + k);
            check($sformatf("A[%0d].underrun", k), 32'(bus.underrun), 32'd0);
            if (k == 7) begin
                tick(1'b0);
                check("blank.valid", 32'(bus.pixel_valid), 32'd0);
                check("blank.R_hold", 32'(bus.R_out), 32'd7);
            end
            if (k == 14) check("A14.sel", 32'(bus.readVgaSelector), 32'd0);
        end
        check("seam.sel", 32'(bus.readVgaSelector), 32'd1);
        bus.full_B = 1'b0;
        bus.R_inA = ramp(8'h40); bus.G_inA = ramp(8'h50); bus.B_inA = ramp(8'h60);
        idle();
        check("idle.valid", 32'(bus.pixel_valid), 32'd0);

        // Stream B, then underrun since A is not full.
        for (int k = 0; k < 16; k++) begin
            tick(1'b1);
            check_pix($sformatf("B[%0d]", k), 128 + k, 144 + k, 160 + k);
        end
        check("ur.underrun", 32'(bus.underrun), 32'd1);
        check("ur.sel", 32'(bus.readVgaSelector), 32'd1);
        for (int j = 0; j < 3; j++) begin
            tick(1'b1);
            check_pix($sformatf("fb[%0d]", j), 8'hFF, 8'h00, 8'hFF);
            check($sformatf("fb[%0d].underrun", j), 32'(bus.underrun), 32'd1);
        end
        check("ur.cnt3", 32'(bus.underrun_cnt), 32'(ExpCnt3));

        // Tick coincides with the load: fallback now, pixel 0 on the next tick.
        bus.full_A = 1'b1;
        tick(1'b1);
        check_pix("fb_load", 8'hFF, 8'h00, 8'hFF);
        check("fb_load.underrun", 32'(bus.underrun), 32'd0);
        check("fb_load.sel", 32'(bus.readVgaSelector), 32'd0);
        check("fb_load.cnt4", 32'(bus.underrun_cnt), 32'(ExpCnt4));
        bus.full_A = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1'b1);
            check_pix($sformatf("A2[%0d]", k), 64 + k, 80 + k, 96 + k);
        end

        // Reset mid-stream.
        reset = 1'b0;
        bus.full_B = 1'b1;
        idle();
        check("mrst.R", 32'(bus.R_out), 32'd0);
        check("mrst.G", 32'(bus.G_out), 32'd0);
        check("mrst.B", 32'(bus.B_out), 32'd0);
        check("mrst.valid", 32'(bus.pixel_valid), 32'd0);
        check("mrst.underrun", 32'(bus.underrun), 32'd0);
        check("mrst.sel", 32'(bus.readVgaSelector), 32'd1);
        check("mrst.cnt", 32'(bus.underrun_cnt), 32'd0);
        reset = 1'b1;
        tick(1'b1);
        check("wait.valid", 32'(bus.pixel_valid), 32'd0);
        check("wait.R", 32'(bus.R_out), 32'd0);
        check("wait.sel", 32'(bus.readVgaSelector), 32'd1);
        bus.full_B = 1'b0;
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
